mem_port_arbiter: RTL and testbench

Multi-cycle sequencer that shares a single-ported memory between instruction fetch and load/store data access for the MIPS core. It sequences every instruction through fetch, optional data access, and commit. It drives the core's `enable` input so the datapath and register file advance exactly once per instruction. It sits between the core (PC, controller, ALU address) and the unified memory.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_perf_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    CHECK  = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } arb_state_t;

  // MIPS primary opcodes (instr[31:26]) for the memory instructions
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/arb_perf_ctr.sv
// Enable-gated 32-bit wrapping event counter.
// Only built when MEM_ARB_PERF_EN is defined; the default build does not use it.
`ifdef MEM_ARB_PERF_EN
module arb_perf_ctr (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: +1 when enabled, natural wrap from all-ones to zero
  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Multi-cycle sequencer sharing one memory port between instruction fetch
// and load/store. Each instruction walks FETCH -> CHECK -> [DATA] -> COMMIT,
// and cpu_enable pulses once in COMMIT so the core advances exactly once.
// Optional MEM_ARB_PERF_EN adds perf_instret / perf_stall counters.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | request instr at pc; latch it on mem_ack
//   CHECK  | one cycle for the core to decode instr (load/store intent)
//   DATA   | load/store access at d_addr; latch load data on mem_ack
//   COMMIT | cpu_enable pulse; core updates PC / register file
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  input  logic          d_re,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] d_rdata,
  output logic          cpu_enable,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_instret,
  output logic [31:0]   perf_stall
`endif
);

  arb_state_t    state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          req_s, we_s, en_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;

  // Next state, Moore memory-side outputs and latch updates
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    d_rdata_d = d_rdata_q;
    req_s     = 1'b0;
    we_s      = 1'b0;
    en_s      = 1'b0;
    addr_s    = '0;
    wdata_s   = '0;
    unique case (state_q)
      FETCH: begin
        req_s  = 1'b1;
        addr_s = pc;
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = (d_re || d_we) ? DATA : COMMIT;
      end
      DATA: begin
        req_s   = 1'b1;
        we_s    = d_we;
        addr_s  = d_addr;
        wdata_s = d_wdata;
        if (mem_ack) begin
          // d_re together with d_we is treated as a store
          if (!d_we) d_rdata_d = mem_rdata;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        en_s    = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State register and instruction / load-data latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      instr_q   <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // FETCH is the reset state, so the request must be masked by reset_n
  // itself for it to drop the moment reset asserts.
  assign mem_req    = req_s & reset_n;
  assign mem_we     = we_s & reset_n;
  assign mem_addr   = reset_n ? addr_s : '0;
  assign mem_wdata  = reset_n ? wdata_s : '0;
  assign cpu_enable = en_s & reset_n;
  assign instr      = instr_q;
  assign d_rdata    = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  arb_perf_ctr u_ctr_instret (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (cpu_enable),
    .count_o (perf_instret)
  );

  arb_perf_ctr u_ctr_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (mem_req & ~mem_ack),
    .count_o (perf_stall)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] pc;
  logic          d_re, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] instr, d_rdata;
  logic          cpu_enable, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_instret, perf_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .d_re       (d_re),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .instr      (instr),
    .d_rdata    (d_rdata),
    .cpu_enable (cpu_enable),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_instret (perf_instret),
    .perf_stall   (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; pc = '0; d_re = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

    // ---- reset state
    tick(); tick();
    #1;
    chk("rst_req",   mem_req, 0);
    chk("rst_en",    cpu_enable, 0);
    chk("rst_instr", instr, 0);
    chk("rst_rdata", d_rdata, 0);

    // ---- fetch stalled 5 cycles, then ALU op 0x20
    tick();
    reset_n = 1'b1; pc = 32'h0000_0100;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  mem_req, 1);
      chk("stall_addr", mem_addr, 32'h100);
      chk("stall_en",   cpu_enable, 0);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
    #1;
    chk("stall_we", mem_we, 0);
    tick();                                   // CHECK
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("stall_chk_en", cpu_enable, 0);
    tick();                                   // COMMIT
    #1;
    chk("stall_commit_en", cpu_enable, 1);
    tick();                                   // FETCH
    #1;
`ifdef MEM_ARB_PERF_EN
    chk("perf_stall",   perf_stall, 5);
    chk("perf_instret", perf_instret, 1);
`endif

    // ---- ALU op, zero-wait: req at 0, enable at 2, next fetch at 3
    pc = 32'h0000_0104; mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
    #1;
    chk("alu_c0_req",  mem_req, 1);
    chk("alu_c0_addr", mem_addr, 32'h104);
    chk("alu_c0_en",   cpu_enable, 0);
    tick();                                   // CHECK, spurious ack
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("alu_c1_req",   mem_req, 0);
    chk("alu_c1_addr",  mem_addr, 0);
    chk("alu_c1_instr", instr, 32'h20);
    tick();                                   // COMMIT
    mem_ack = 1'b0;
    #1;
    chk("alu_c2_en",    cpu_enable, 1);
    chk("alu_c2_req",   mem_req, 0);
    chk("alu_c2_instr", instr, 32'h20);
    tick();                                   // FETCH
    #1;
    chk("alu_c3_req", mem_req, 1);
    chk("alu_c3_en",  cpu_enable, 0);

    // ---- LW 0x40, two wait cycles, returns 0xDEADBEEF
    pc = 32'h0000_0108; mem_ack = 1'b1; mem_rdata = 32'h8C00_0040;
    tick();                                   // CHECK
    mem_ack = 1'b0; mem_rdata = '0; d_re = 1'b1; d_addr = 32'h40;
    #1;
    chk("lw_instr", instr, 32'h8C00_0040);
    tick();                                   // DATA
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      #1;
      chk("lw_req",  mem_req, 1);
      chk("lw_we",   mem_we, 0);
      chk("lw_addr", mem_addr, 32'h40);
      chk("lw_en",   cpu_enable, 0);
      tick();
    end
    mem_ack = 1'b0; mem_rdata = '0;           // COMMIT
    #1;
    chk("lw_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("lw_en_commit", cpu_enable, 1);
    tick();
    d_re = 1'b0;
    #1;
    chk("lw_en_after", cpu_enable, 0);

    // ---- SW 0x44 <- 0x12345678, zero-wait; spurious ack in COMMIT
    pc = 32'h0000_010C; mem_ack = 1'b1; mem_rdata = 32'hAC00_0044;
    tick();                                   // CHECK
    mem_ack = 1'b0; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
    tick();                                   // DATA
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("sw_req",   mem_req, 1);
    chk("sw_we",    mem_we, 1);
    chk("sw_addr",  mem_addr, 32'h44);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    tick();                                   // COMMIT
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    chk("sw_req_commit", mem_req, 0);
    chk("sw_we_commit",  mem_we, 0);
    chk("sw_rdata",      d_rdata, 32'hDEAD_BEEF);
    chk("sw_en",         cpu_enable, 1);
    tick();                                   // FETCH
    mem_ack = 1'b0; d_we = 1'b0; pc = 32'h0000_0110;
    #1;
    chk("spur_instr", instr, 32'hAC00_0044);
    chk("spur_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("spur_req",   mem_req, 1);
    chk("spur_en",    cpu_enable, 0);

    // ---- reset during a DATA wait; late ack during reset is ignored
    mem_ack = 1'b1; mem_rdata = 32'h8C00_0048;
    tick();                                   // CHECK
    mem_ack = 1'b0; d_re = 1'b1; d_addr = 32'h48;
    tick();                                   // DATA, waiting
    #1;
    chk("rd_req_before", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rd_req_rst",   mem_req, 0);
    chk("rd_en_rst",    cpu_enable, 0);
    chk("rd_addr_rst",  mem_addr, 0);
    chk("rd_instr_rst", instr, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; d_re = 1'b0;
    reset_n = 1'b1; pc = 32'h0000_0200;
    #1;
    chk("rd_post_req",   mem_req, 1);
    chk("rd_post_addr",  mem_addr, 32'h200);
    chk("rd_post_instr", instr, 0);
    chk("rd_post_rdata", d_rdata, 0);
    tick();
    #1;
    chk("rd_post_hold_req",   mem_req, 1);
    chk("rd_post_hold_instr", instr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
